mem_access_unit: RTL

//  Load/store sequencer between the execute stage and the 4 KB word-organised data memory.

---
 rtl/mem_access_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and a word-organised data memory.
// Requests are taken one at a time. Alignment, range and size are checked when a
// request is accepted. Byte and halfword stores are done as read-modify-write.
// Loads are extracted from big-endian lanes and then sign- or zero-extended.
module mem_access_unit #(
    parameter int DM_AW  = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [DATA_W-1:0] dm_din,
    output logic [1:0]        dm_byteExt,
    output logic [1:0]        dm_wEn,
    input  logic [DATA_W-1:0] dm_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    state_t            state_q;
    logic              we_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [15:0]       wdata_q;
    logic [DM_AW-1:0]  dm_addr_q;
    logic [DATA_W-1:0] dm_din_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] ld_data_s;
    logic [DATA_W-1:0] mg_data_s;

    // The request is rejected for an illegal size, a misaligned address, or an address beyond the memory.
    function automatic logic req_bad(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        bad = 1'b0;
        if (size == 2'b11) begin
            bad = 1'b1;
        end else if ((size == 2'b00) && (addr[1:0] != 2'b00)) begin
            bad = 1'b1;
        end else if ((size == 2'b10) && addr[0]) begin
            bad = 1'b1;
        end else if ((addr >> DM_AW) != 32'd0) begin
            bad = 1'b1;
        end else begin
            bad = 1'b0;
        end
        return bad;
    endfunction

    // Selects a big-endian lane and extends it. Byte offset 0 is in the top byte.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = 32'd0;
        res = word;
        case (size)
            2'b01: begin
                sh  = word >> {~off, 3'b000};
                res = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
            end
            2'b10: begin
                sh  = word >> {~off[1], 4'b0000};
                res = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
            end
            default: begin
                res = word;
            end
        endcase
        return res;
    endfunction

    // Replaces one byte or halfword lane of the word that was read with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic [15:0] wd);
        logic [4:0]  sh;
        logic [31:0] mask;
        logic [31:0] ins;
        sh   = 5'd0;
        mask = 32'd0;
        ins  = 32'd0;
        case (size)
            2'b01: begin
                sh   = {~off, 3'b000};
                mask = 32'h0000_00FF << sh;
                ins  = {24'd0, wd[7:0]} << sh;
            end
            2'b10: begin
                sh   = {~off[1], 4'b0000};
                mask = 32'h0000_FFFF << sh;
                ins  = {16'd0, wd} << sh;
            end
            default: begin
                mask = 32'd0;
                ins  = 32'd0;
            end
        endcase
        return (word & ~mask) | ins;
    endfunction

    // Load extraction and store merge work on the word that memory returns for the latched address.
    always_comb begin
        ld_data_s = load_extract(dm_dout, size_q, off_q, signed_q);
        mg_data_s = store_merge(dm_dout, size_q, off_q, wdata_q);
    end

    // Sequencer FSM. It also holds the latched request and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            wdata_q   <= 16'd0;
            dm_addr_q <= '0;
            dm_din_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        signed_q  <= req_signed;
                        size_q    <= req_size;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        dm_addr_q <= {req_addr[DM_AW-1:2], 2'b00};
                        if (req_bad(req_size, req_addr)) begin
                            rdata_q  <= '0;
                            err_q    <= 1'b1;
                            rvalid_q <= 1'b1;
                            state_q  <= ST_RESP;
                        end else if (req_we && (req_size == 2'b00)) begin
                            dm_din_q <= req_wdata;
                            state_q  <= ST_WR;
                        end else begin
                            state_q  <= ST_RD;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (we_q) begin
                        dm_din_q <= mg_data_s;
                        state_q  <= ST_WR;
                    end else begin
                        rdata_q  <= ld_data_s;
                        err_q    <= 1'b0;
                        rvalid_q <= 1'b1;
                        state_q  <= ST_RESP;
                    end
                end
                ST_WR: begin
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                    rvalid_q <= 1'b1;
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        rdata_q  <= '0;
                        err_q    <= 1'b0;
                        rvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dm_addr    = dm_addr_q;
    assign dm_din     = dm_din_q;
    assign dm_byteExt = 2'b00;
    assign dm_wEn     = (state_q == ST_WR) ? 2'b01 : 2'b00;

endmodule
